// File: rtl/hyperram_wb_bridge.sv
// rtl/hyperram_wb_bridge.sv - Wishbone-classic slave issuing one-shot hyperram controller transactions
// Writes are posted; reads ack once the controller's last-cycle read word is captured.

module hyperram_wb_bridge #(
    parameter int WAIT_LATENCY = 6,
    parameter int DONE_LATENCY = 2,
    parameter int TXN_OVERHEAD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        transaction_begin,
    output logic        write_enable,
    output logic [31:0] address,
    output logic [3:0]  write_mask,
    output logic [31:0] data_out,
    output logic [5:0]  wait_latency,
    output logic [5:0]  done_latency,
    input  logic [31:0] read_data
);

    localparam int N = TXN_OVERHEAD + WAIT_LATENCY + DONE_LATENCY;
    localparam logic [7:0] BUSY_LOAD = 8'(N - 1);

    generate
        if (N < 2 || N > 255) begin : g_bad_txn_length
            $error("hyperram_wb_bridge: transaction length out of range 2..255");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [7:0]  busy_cnt_q, busy_cnt_d;
    logic        is_read_q, is_read_d;
    logic        wb_ack_q, wb_ack_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    logic        txn_begin_q, txn_begin_d;
    logic        write_enable_q, write_enable_d;
    logic [31:0] address_q, address_d;
    logic [3:0]  write_mask_q, write_mask_d;
    logic [31:0] data_out_q, data_out_d;
    logic        live;

    assign live = wb_cyc_i & wb_stb_i;

    always_comb begin
        state_d        = state_q;
        busy_cnt_d     = busy_cnt_q;
        is_read_d      = is_read_q;
        wb_ack_d       = 1'b0;
        wb_dat_d       = wb_dat_q;
        txn_begin_d    = 1'b0;
        write_enable_d = write_enable_q;
        address_d      = address_q;
        write_mask_d   = write_mask_q;
        data_out_d     = data_out_q;
        case (state_q)
            IDLE: begin
                // Ack still high means this strobe belongs to the request just completed.
                if (live && !wb_ack_q) begin
                    address_d      = wb_adr_i;
                    write_enable_d = wb_we_i;
                    data_out_d     = wb_dat_i;
                    write_mask_d   = wb_we_i ? ~wb_sel_i : 4'b0000;
                    is_read_d      = !wb_we_i;
                    txn_begin_d    = 1'b1;
                    wb_ack_d       = wb_we_i;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                busy_cnt_d = BUSY_LOAD;
                if (!live) begin
                    is_read_d = 1'b0;
                end
                state_d = BUSY;
            end
            BUSY: begin
                busy_cnt_d = busy_cnt_q - 8'd1;
                // A dropped strobe abandons the read for good, even if a new strobe follows.
                if (!live) begin
                    is_read_d = 1'b0;
                end
                if (busy_cnt_q <= 8'd1) begin
                    if (is_read_q && live) begin
                        wb_dat_d = read_data;
                        wb_ack_d = 1'b1;
                    end
                    is_read_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            busy_cnt_q     <= 8'd0;
            is_read_q      <= 1'b0;
            wb_ack_q       <= 1'b0;
            wb_dat_q       <= 32'd0;
            txn_begin_q    <= 1'b0;
            write_enable_q <= 1'b0;
            address_q      <= 32'd0;
            write_mask_q   <= 4'b0000;
            data_out_q     <= 32'd0;
        end else begin
            state_q        <= state_d;
            busy_cnt_q     <= busy_cnt_d;
            is_read_q      <= is_read_d;
            wb_ack_q       <= wb_ack_d;
            wb_dat_q       <= wb_dat_d;
            txn_begin_q    <= txn_begin_d;
            write_enable_q <= write_enable_d;
            address_q      <= address_d;
            write_mask_q   <= write_mask_d;
            data_out_q     <= data_out_d;
        end
    end

    assign wb_ack_o          = wb_ack_q;
    assign wb_dat_o          = wb_dat_q;
    assign transaction_begin = txn_begin_q;
    assign write_enable      = write_enable_q;
    assign address           = address_q;
    assign write_mask        = write_mask_q;
    assign data_out          = data_out_q;
    assign wait_latency      = 6'(WAIT_LATENCY);
    assign done_latency      = 6'(DONE_LATENCY);

endmodule

// File: tb/tb_hyperram_wb_bridge.sv
// tb/tb_hyperram_wb_bridge.sv - directed self-checking bench for hyperram_wb_bridge

module tb_hyperram_wb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        transaction_begin, write_enable;
    logic [31:0] address, data_out;
    logic [3:0]  write_mask;
    logic [5:0]  wait_latency, done_latency;
    logic [31:0] read_data;

    int checks   = 0;
    int failures = 0;

    hyperram_wb_bridge dut (
        .clk               (clk),
        .rst               (rst),
        .wb_cyc_i          (wb_cyc_i),
        .wb_stb_i          (wb_stb_i),
        .wb_we_i           (wb_we_i),
        .wb_adr_i          (wb_adr_i),
        .wb_dat_i          (wb_dat_i),
        .wb_sel_i          (wb_sel_i),
        .wb_ack_o          (wb_ack_o),
        .wb_dat_o          (wb_dat_o),
        .transaction_begin (transaction_begin),
        .write_enable      (write_enable),
        .address           (address),
        .write_mask        (write_mask),
        .data_out          (data_out),
        .wait_latency      (wait_latency),
        .done_latency      (done_latency),
        .read_data         (read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"},  32'(wb_ack_o), 32'd0);
        chk({tag, "_dat"},  wb_dat_o, 32'd0);
        chk({tag, "_tb"},   32'(transaction_begin), 32'd0);
        chk({tag, "_we"},   32'(write_enable), 32'd0);
        chk({tag, "_adr"},  address, 32'd0);
        chk({tag, "_mask"}, 32'(write_mask), 32'd0);
        chk({tag, "_dout"}, data_out, 32'd0);
        chk({tag, "_wait"}, 32'(wait_latency), 32'd6);
        chk({tag, "_done"}, 32'(done_latency), 32'd2);
    endtask

    initial begin
        rst = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
        read_data = 32'hDEADBEEF;

        // Reset held two cycles with a live strobe
        step(); check_reset_outputs("rst1");
        step(); check_reset_outputs("rst2");
        rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();
        chk("idle_tb", 32'(transaction_begin), 32'd0);

        // Single read
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h12345678;
        step();
        chk("rd_tb_t1",   32'(transaction_begin), 32'd1);
        chk("rd_we_t1",   32'(write_enable), 32'd0);
        chk("rd_mask_t1", 32'(write_mask), 32'd0);
        chk("rd_adr_t1",  address, 32'h12345678);
        chk("rd_ack_t1",  32'(wb_ack_o), 32'd0);
        for (int c = 2; c <= 17; c++) begin
            step();
            read_data = (c == 16) ? 32'hCCCCDDDD : 32'hDEADBEEF;
            chk("rd_tb", 32'(transaction_begin), 32'd0);
            chk("rd_ack", 32'(wb_ack_o), 32'(c == 17));
            if (c == 17) chk("rd_dat", wb_dat_o, 32'hCCCCDDDD);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();
        chk("rd_ack_single", 32'(wb_ack_o), 32'd0);

        // Posted write followed by a read raised at T+2
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h00000010; wb_dat_i = 32'hA5A5A5A5; wb_sel_i = 4'b0011;
        step();
        chk("wr_ack_t1",  32'(wb_ack_o), 32'd1);
        chk("wr_tb_t1",   32'(transaction_begin), 32'd1);
        chk("wr_mask_t1", 32'(write_mask), 32'hC);
        chk("wr_dout_t1", data_out, 32'hA5A5A5A5);
        chk("wr_we_t1",   32'(write_enable), 32'd1);
        chk("wr_adr_t1",  address, 32'h00000010);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        for (int c = 2; c <= 34; c++) begin
            step();
            if (c == 2) begin
                wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
                wb_adr_i = 32'h00000020; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
            end
            read_data = (c == 33) ? 32'h11223344 : 32'hDEADBEEF;
            chk("b2b_tb", 32'(transaction_begin), 32'(c == 18));
            chk("b2b_ack", 32'(wb_ack_o), 32'(c == 34));
            if (c <= 17) begin
                chk("wr_hold_adr",  address, 32'h00000010);
                chk("wr_hold_mask", 32'(write_mask), 32'hC);
                chk("wr_hold_we",   32'(write_enable), 32'd1);
                chk("wr_hold_dout", data_out, 32'hA5A5A5A5);
            end
            if (c == 18) begin
                chk("b2b_rd_adr",  address, 32'h00000020);
                chk("b2b_rd_we",   32'(write_enable), 32'd0);
                chk("b2b_rd_mask", 32'(write_mask), 32'd0);
            end
            if (c == 34) chk("b2b_rd_dat", wb_dat_o, 32'h11223344);
        end
        // Strobe left high through the ack cycle must not be re-accepted
        step();
        chk("no_reaccept_tb",  32'(transaction_begin), 32'd0);
        chk("no_reaccept_ack", 32'(wb_ack_o), 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();

        // Aborted read, then a new read strobed at T+10
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h00000040;
        step();
        chk("ab_tb_t1", 32'(transaction_begin), 32'd1);
        for (int c = 2; c <= 34; c++) begin
            step();
            if (c == 5) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
            if (c == 10) begin
                wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h00000080;
            end
            read_data = (c == 16) ? 32'h55555555 : (c == 33) ? 32'h66666666 : 32'hDEADBEEF;
            chk("ab_tb", 32'(transaction_begin), 32'(c == 18));
            chk("ab_ack", 32'(wb_ack_o), 32'(c == 34));
            if (c == 17) chk("ab_dat_kept", wb_dat_o, 32'h11223344);
            if (c == 18) chk("ab_new_adr", address, 32'h00000080);
            if (c == 34) chk("ab_new_dat", wb_dat_o, 32'h66666666);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();

        // Reset during BUSY, then a read accepted straight out of reset
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h00000100;
        step();
        chk("rb_tb_t1", 32'(transaction_begin), 32'd1);
        for (int c = 2; c <= 8; c++) step();
        rst = 1'b1;
        step();
        chk("rb_ack_after_rst", 32'(wb_ack_o), 32'd0);
        chk("rb_tb_after_rst",  32'(transaction_begin), 32'd0);
        chk("rb_adr_after_rst", address, 32'd0);
        rst = 1'b0; wb_adr_i = 32'h00000200;
        step();
        chk("rb_new_tb",  32'(transaction_begin), 32'd1);
        chk("rb_new_adr", address, 32'h00000200);
        for (int c = 2; c <= 17; c++) begin
            step();
            read_data = (c == 16) ? 32'h0BADF00D : 32'hDEADBEEF;
            chk("rb_ack", 32'(wb_ack_o), 32'(c == 17));
            if (c == 17) chk("rb_dat", wb_dat_o, 32'h0BADF00D);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hyperram_wb_bridge.md
# hyperram_wb_bridge

Wishbone-classic slave that converts single 32-bit bus reads and writes into one-shot transactions on the `hyperram` controller's command port. It sits directly upstream of `hyperram`: it registers the request, pulses `transaction_begin`, holds command fields stable for the whole transaction, and times completion from the controller's configured latencies. Writes are posted (acked immediately); reads are acked when the controller's read word is valid.

## Interface
Parameters:
- `WAIT_LATENCY`, default 6: driven onto `wait_latency`; range 0..63.
- `DONE_LATENCY`, default 2: driven onto `done_latency`; range 0..63.
- `TXN_OVERHEAD`, default 8: fixed CA and data-phase cycles per transaction.
- Transaction length is N = TXN_OVERHEAD + WAIT_LATENCY + DONE_LATENCY, default 16. N must be in 2..255; elaboration fails outside this range.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: 1 = write.
- `wb_adr_i` in 32: byte address, passed through unmodified.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte enables, active-high.
- `wb_ack_o` out 1: single-cycle acknowledge.
- `wb_dat_o` out 32: read data.
- `transaction_begin` out 1: one-cycle start pulse to the controller.
- `write_enable` out 1: to controller.
- `address` out 32: to controller.
- `write_mask` out 4: to controller; 1 = byte masked.
- `data_out` out 32: write data to controller.
- `wait_latency` out 6: constant WAIT_LATENCY.
- `done_latency` out 6: constant DONE_LATENCY.
- `read_data` in 32: controller read word; valid on the last cycle of the transaction.

## Operation
- States: IDLE, ISSUE, BUSY.
- IDLE:
  - When `wb_cyc_i & wb_stb_i & !wb_ack_o`, latch `address`←`wb_adr_i`, `write_enable`←`wb_we_i`, `data_out`←`wb_dat_i`.
  - `write_mask`←`~wb_sel_i` for writes, 4'b0000 for reads.
  - Record `is_read = !wb_we_i`, then go to ISSUE.
- ISSUE (exactly one cycle):
  - `transaction_begin`=1.
  - Load 8-bit `busy_cnt` with N-1.
  - If write, assert `wb_ack_o` this cycle (posted write).
  - Go to BUSY.
- BUSY:
  - Decrement `busy_cnt` each cycle.
  - When `busy_cnt`==1: if `is_read` and the request is still live (`wb_cyc_i & wb_stb_i`), capture `wb_dat_o`←`read_data` and assert `wb_ack_o` on the next cycle.
  - Go to IDLE.
- Command fields (`address`, `write_enable`, `write_mask`, `data_out`) hold stable from ISSUE until the next accept; they change only in IDLE on accept.
- Aborted read (master drops `wb_stb_i` or `wb_cyc_i` during BUSY): the controller transaction runs to completion, no ack is issued, and `wb_dat_o` is not updated.
- No new request is accepted while in ISSUE or BUSY; a posted write therefore stalls the next request until its transaction ends.
- `wb_ack_o` is never high for two consecutive cycles.
- `rst` in any state:
  - Next cycle: state=IDLE, `busy_cnt`=0, `is_read`=0.
  - Any in-flight transaction is dropped with no ack; the controller shares the same `rst`.

## Timing
- Reset values:
  - `wb_ack_o`=0, `wb_dat_o`=0, `transaction_begin`=0, `write_enable`=0.
  - `address`=0, `write_mask`=0, `data_out`=0.
  - `wait_latency`=WAIT_LATENCY, `done_latency`=DONE_LATENCY.
- Request sampled in IDLE at edge T:
  - `transaction_begin` is high in cycle T+1.
  - Controller transaction occupies cycles T+1 .. T+N.
- Write: `wb_ack_o` high in cycle T+1.
- Read: `wb_ack_o` high in cycle T+N+1, with `wb_dat_o` = `read_data` sampled in cycle T+N. Default read latency is 17 cycles.
- Return to IDLE: the block is in IDLE in cycle T+N+1 and can sample a new request at the end of that cycle. The next `transaction_begin` is no earlier than T+N+2.
- A request present in IDLE while `wb_ack_o` is high is not sampled. This prevents double-accepting a request whose strobe has not yet fallen.

## Test plan
- Reset: assert `rst` for 2 cycles with `wb_stb_i`=1 → all outputs at reset values, no `transaction_begin`; `wait_latency`=6, `done_latency`=2.
- Single read: adr 0x12345678, `read_data`=0xCCCCDDDD at T+16 → `transaction_begin` only at T+1, `write_enable`=0, `write_mask`=0; `wb_ack_o` only at T+17 with `wb_dat_o`=0xCCCCDDDD.
- Posted write: adr 0x00000010, dat 0xA5A5A5A5, sel 4'b0011 → `write_mask`=4'b1100, `data_out`=0xA5A5A5A5, `write_enable`=1, `wb_ack_o` at T+1; fields stable through T+16.
- Write then read back-to-back (read strobe raised at T+2) → read's `transaction_begin` at T+18, read ack at T+34; no command field changes before T+17.
- Aborted read: drop `wb_stb_i` at T+5 → no ack, `wb_dat_o` unchanged; a new read strobed at T+10 gets `transaction_begin` at T+18.
- Reset mid-BUSY at T+8 → IDLE next cycle, no ack; a new read strobed immediately after reset gets `transaction_begin` exactly one cycle after acceptance.
